mic_array_cic_sequencer: RTL and testbench

//  Sequences a bank of NCH PDM-to-PCM CIC decimators in the acoustic camera front end.

---
 rtl/mic_array_cic_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_mic_array_cic_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mic_array_cic_sequencer.sv
// mic_array_cic_sequencer
//   Drives a bank of NCH PDM-to-PCM CIC decimators. It generates the PDM mic
//   clock, the integrator enable and the comb decimation strobe. It throws away
//   the first SETTLE decimated outputs after enable, while the CIC start-up
//   transient is still present. After that it snapshots all channel outputs
//   once per decimation period and sends them out round-robin on one
//   valid/ready stream.
//
// Ports
//   clk, rst        system clock, asynchronous active-high reset
//   en              run request
//   pdm_clk_out     mic clock, 50% duty, period CLKDIV clk
//   pdm_ce          1-cycle integrator enable, once per PDM bit
//   dec_stb         1-cycle comb enable, once per R pdm_ce
//   ch_data         CIC outputs, channel i at [i*W +: W]
//   m_valid/m_ready stream handshake
//   m_data, m_chan  sample and its channel index
//   m_last          high with channel NCH-1 (end of frame)
//   overrun         sticky, set when a frame had to be dropped
//   clr_overrun     clears overrun (a set in the same cycle wins)
//   busy            sequencer is not idle
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | stopped, divider held at 0, mic clock low
// SETTLE  | running, discarding the first SETTLE decimation strobes
// WAIT    | waiting for the next decimation strobe
// CAPTURE | one cycle: CIC outputs are now valid, latch them into the shadow
// SEND    | streaming shadow[0..NCH-1]; leaves after the last handshake

module mic_array_cic_sequencer #(
   parameter int NCH    = 4,
   parameter int W      = 17,
   parameter int CLKDIV = 4,
   parameter int R      = 8,
   parameter int SETTLE = 3,
   localparam int CHW   = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   output logic             pdm_clk_out,
   output logic             pdm_ce,
   output logic             dec_stb,
   input  logic [NCH*W-1:0] ch_data,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [W-1:0]     m_data,
   output logic [CHW-1:0]   m_chan,
   output logic             m_last,
   output logic             overrun,
   input  logic             clr_overrun,
   output logic             busy
);

   localparam int DW = $clog2(CLKDIV);
   localparam int RW = (R > 1) ? $clog2(R) : 1;
   localparam int SW = $clog2(SETTLE + 1);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_SETTLE  = 3'd1;
   localparam logic [2:0] S_WAIT    = 3'd2;
   localparam logic [2:0] S_CAPTURE = 3'd3;
   localparam logic [2:0] S_SEND    = 3'd4;

   logic [2:0]     r_state;
   logic [DW-1:0]  r_div_cnt;
   logic [RW-1:0]  r_dec_cnt;
   logic [SW-1:0]  r_settle_cnt;
   logic           r_pdm_clk;
   logic           r_pdm_ce;
   logic           r_dec_stb;
   logic           r_stop;
   logic           r_overrun;
   logic           r_m_valid;
   logic [W-1:0]   r_m_data;
   logic [CHW-1:0] r_m_chan;
   logic           r_m_last;
   logic [CHW-1:0] r_idx;
   logic [W-1:0]   r_shadow [NCH];

   logic [2:0]     w_state_nxt;
   logic [DW-1:0]  w_div_nxt;
   logic [CHW-1:0] w_idx_inc;
   logic           w_hs;
   logic           w_last_idx;

   assign w_hs       = r_m_valid & m_ready;
   assign w_last_idx = (r_idx == CHW'(NCH - 1));
   assign w_idx_inc  = r_idx + 1'b1;

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE:    if (en) w_state_nxt = S_SETTLE;
         S_SETTLE: begin
            if (!en)
               w_state_nxt = S_IDLE;
            else if (r_dec_stb && (r_settle_cnt == SW'(SETTLE - 1)))
               w_state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (!en)
               w_state_nxt = S_IDLE;
            else if (r_dec_stb)
               w_state_nxt = S_CAPTURE;
         end
         S_CAPTURE: w_state_nxt = en ? S_SEND : S_IDLE;
         S_SEND: begin
            // a disable seen at any point during the frame ends it in IDLE
            if (w_hs && w_last_idx)
               w_state_nxt = (r_stop || !en) ? S_IDLE : S_WAIT;
         end
         default:   w_state_nxt = S_IDLE;
      endcase
   end

   // Divider restarts from 0 on every entry into a running state, so the
   // first mic clock phase after enable is always a full high phase.
   always_comb begin
      w_div_nxt = '0;
      if ((w_state_nxt != S_IDLE) && (r_state != S_IDLE))
         w_div_nxt = (r_div_cnt == DW'(CLKDIV - 1)) ? '0 : r_div_cnt + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_div_cnt    <= '0;
         r_dec_cnt    <= '0;
         r_settle_cnt <= '0;
         r_pdm_clk    <= 1'b0;
         r_pdm_ce     <= 1'b0;
         r_dec_stb    <= 1'b0;
         r_stop       <= 1'b0;
         r_overrun    <= 1'b0;
         r_m_valid    <= 1'b0;
         r_m_data     <= '0;
         r_m_chan     <= '0;
         r_m_last     <= 1'b0;
         r_idx        <= '0;
         for (int i = 0; i < NCH; i++)
            r_shadow[i] <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_div_cnt <= w_div_nxt;
         // mic clock and enable are computed from next-cycle values so they
         // line up exactly with r_div_cnt
         r_pdm_clk <= (w_state_nxt != S_IDLE) && (w_div_nxt < DW'(CLKDIV / 2));
         r_pdm_ce  <= (w_state_nxt != S_IDLE) && (w_div_nxt == DW'(CLKDIV - 1));

         if (w_state_nxt == S_IDLE)
            r_dec_cnt <= '0;
         else if (r_pdm_ce)
            r_dec_cnt <= (r_dec_cnt == RW'(R - 1)) ? '0 : r_dec_cnt + 1'b1;

         r_dec_stb <= r_pdm_ce && (r_dec_cnt == RW'(R - 1)) && (w_state_nxt != S_IDLE);

         if (r_state == S_IDLE)
            r_settle_cnt <= '0;
         else if ((r_state == S_SETTLE) && r_dec_stb)
            r_settle_cnt <= r_settle_cnt + 1'b1;

         if (r_state != S_SEND)
            r_stop <= 1'b0;
         else if (!en)
            r_stop <= 1'b1;

         if (r_dec_stb && ((r_state == S_CAPTURE) || (r_state == S_SEND)))
            r_overrun <= 1'b1;
         else if (clr_overrun)
            r_overrun <= 1'b0;

         // CICs update on the dec_stb edge, so the capture cycle sees fresh data;
         // channel 0 is also loaded straight into the output register.
         if ((r_state == S_CAPTURE) && en) begin
            for (int i = 0; i < NCH; i++)
               r_shadow[i] <= ch_data[i*W +: W];
            r_m_valid <= 1'b1;
            r_m_data  <= ch_data[W-1:0];
            r_m_chan  <= '0;
            r_m_last  <= (NCH == 1);
            r_idx     <= '0;
         end else if ((r_state == S_SEND) && w_hs) begin
            if (w_last_idx) begin
               r_m_valid <= 1'b0;
               r_m_data  <= '0;
               r_m_chan  <= '0;
               r_m_last  <= 1'b0;
               r_idx     <= '0;
            end else begin
               r_idx    <= w_idx_inc;
               r_m_data <= r_shadow[w_idx_inc];
               r_m_chan <= w_idx_inc;
               r_m_last <= (w_idx_inc == CHW'(NCH - 1));
            end
         end
      end
   end

   assign pdm_clk_out = r_pdm_clk;
   assign pdm_ce      = r_pdm_ce;
   assign dec_stb     = r_dec_stb;
   assign m_valid     = r_m_valid;
   assign m_data      = r_m_data;
   assign m_chan      = r_m_chan;
   assign m_last      = r_m_last;
   assign overrun     = r_overrun;
   assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_mic_array_cic_sequencer.sv
// Directed bench for mic_array_cic_sequencer with NCH=4, W=17, CLKDIV=4,
// R=8, SETTLE=3. Inputs change and outputs are sampled 1 time unit after
// each rising clock edge.

module tb_mic_array_cic_sequencer;

   localparam int NCH    = 4;
   localparam int W      = 17;
   localparam int CLKDIV = 4;
   localparam int R      = 8;
   localparam int SETTLE = 3;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             en = 1'b0;
   logic             m_ready = 1'b0;
   logic             clr_overrun = 1'b0;
   logic [NCH*W-1:0] ch_data;
   logic             pdm_clk_out, pdm_ce, dec_stb;
   logic             m_valid, m_last, overrun, busy;
   logic [W-1:0]     m_data;
   logic [1:0]       m_chan;

   int n_chk = 0;
   int n_fail = 0;
   int stb_cnt = 0;

   mic_array_cic_sequencer #(
      .NCH(NCH), .W(W), .CLKDIV(CLKDIV), .R(R), .SETTLE(SETTLE)
   ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .pdm_clk_out (pdm_clk_out),
      .pdm_ce      (pdm_ce),
      .dec_stb     (dec_stb),
      .ch_data     (ch_data),
      .m_valid     (m_valid),
      .m_ready     (m_ready),
      .m_data      (m_data),
      .m_chan      (m_chan),
      .m_last      (m_last),
      .overrun     (overrun),
      .clr_overrun (clr_overrun),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (dec_stb) stb_cnt++;
   endtask

   task automatic wait_stb(input int limit, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!dec_stb && (n < limit));
   endtask

   task automatic wait_valid(input int limit, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!m_valid && (n < limit));
   endtask

   task automatic check_word(input string tag, input int i);
      check_val({tag, "_valid"}, m_valid, 1);
      check_val({tag, "_data"}, m_data, i + 1);
      check_val({tag, "_chan"}, m_chan, i);
      check_val({tag, "_last"}, m_last, (i == NCH - 1) ? 1 : 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int first_stb;
      int first_ovr;
      logic [7:0] exp_clk;
      logic [7:0] exp_ce;

      ch_data = {17'd4, 17'd3, 17'd2, 17'd1};
      exp_clk = 8'b0011_0011;
      exp_ce  = 8'b1000_1000;

      // reset state
      tick(); tick();
      check_val("rst_valid", m_valid, 0);
      check_val("rst_busy", busy, 0);
      check_val("rst_pdmclk", pdm_clk_out, 0);
      check_val("rst_ce", pdm_ce, 0);
      check_val("rst_stb", dec_stb, 0);
      check_val("rst_ovr", overrun, 0);
      rst = 1'b0;
      tick(); tick();
      check_val("idle_busy", busy, 0);
      check_val("idle_pdmclk", pdm_clk_out, 0);

      // clock generation and start-up latency
      m_ready = 1'b1;
      en = 1'b1;
      stb_cnt = 0;
      for (int c = 0; c < 8; c++) begin
         tick();
         check_val($sformatf("pdmclk_%0d", c), pdm_clk_out, exp_clk[c]);
         check_val($sformatf("pdmce_%0d", c), pdm_ce, exp_ce[c]);
      end
      check_val("busy_run", busy, 1);
      wait_stb(100, n); check_val("stb1_gap", n, 25);
      wait_stb(100, n); check_val("stb2_gap", n, 32);
      wait_stb(100, n); check_val("stb3_gap", n, 32);
      check_val("settle_novalid", m_valid, 0);
      wait_stb(100, n); check_val("stb4_gap", n, 32);
      wait_valid(100, n); check_val("first_valid_lat", n, 2);
      check_val("stb_before_frame", stb_cnt, 4);

      // frame with m_ready held high
      for (int i = 0; i < NCH; i++) begin
         check_word($sformatf("frame0_%0d", i), i);
         tick();
      end
      check_val("frame0_end", m_valid, 0);

      // backpressure: ready alternates, each word must hold while stalled
      wait_valid(100, n); check_val("frame1_gap", n, 28);
      for (int i = 0; i < NCH; i++) begin
         check_word($sformatf("bp_%0d", i), i);
         m_ready = 1'b0;
         tick();
         check_word($sformatf("bp_hold_%0d", i), i);
         m_ready = 1'b1;
         tick();
      end
      check_val("bp_end", m_valid, 0);

      // overrun: stall across the next decimation strobe
      m_ready = 1'b0;
      wait_valid(100, n); check_val("frame2_gap", n, 24);
      first_stb = 0;
      first_ovr = 0;
      for (int t = 1; t <= 40; t++) begin
         tick();
         if (dec_stb && first_stb == 0) first_stb = t;
         if (overrun && first_ovr == 0) first_ovr = t;
      end
      check_val("ovr_stb_tick", first_stb, 30);
      check_val("ovr_set_tick", first_ovr, 31);
      m_ready = 1'b1;
      for (int i = 0; i < NCH; i++) begin
         check_word($sformatf("ovr_frame_%0d", i), i);
         tick();
      end
      check_val("ovr_frame_end", m_valid, 0);
      check_val("ovr_sticky", overrun, 1);
      clr_overrun = 1'b1;
      tick();
      clr_overrun = 1'b0;
      check_val("ovr_clear", overrun, 0);

      // the overrun strobe's frame was dropped; next frame follows the next strobe
      m_ready = 1'b0;
      wait_valid(100, n); check_val("drop_gap", n, 19);
      wait_stb(100, n); check_val("clrset_stb_gap", n, 30);
      clr_overrun = 1'b1;
      tick();
      clr_overrun = 1'b0;
      check_val("clr_and_set", overrun, 1);
      m_ready = 1'b1;
      for (int i = 0; i < NCH; i++) begin
         check_word($sformatf("clrset_frame_%0d", i), i);
         tick();
      end
      check_val("clrset_end", m_valid, 0);
      clr_overrun = 1'b1;
      tick();
      clr_overrun = 1'b0;
      check_val("ovr_clear2", overrun, 0);

      // disable mid-frame: frame completes, then idle
      wait_valid(100, n); check_val("frame4_gap", n, 28);
      check_word("dis_0", 0);
      tick();
      check_word("dis_1", 1);
      tick();
      en = 1'b0;
      check_word("dis_2", 2);
      tick();
      check_word("dis_3", 3);
      check_val("dis_busy_send", busy, 1);
      tick();
      check_val("dis_valid", m_valid, 0);
      check_val("dis_busy", busy, 0);
      check_val("dis_pdmclk", pdm_clk_out, 0);
      stb_cnt = 0;
      for (int t = 0; t < 40; t++) tick();
      check_val("dis_no_stb", stb_cnt, 0);
      check_val("dis_busy_later", busy, 0);

      // re-enable passes through settling again
      en = 1'b1;
      stb_cnt = 0;
      wait_valid(200, n);
      check_val("reen_lat", n, 131);
      check_val("reen_stb", stb_cnt, 4);
      check_val("reen_data", m_data, 1);
      for (int t = 0; t < NCH; t++) tick();
      check_val("reen_end", m_valid, 0);

      // asynchronous reset in the middle of a stalled frame
      m_ready = 1'b0;
      wait_valid(100, n); check_val("rstf_gap", n, 28);
      wait_stb(100, n); check_val("rstf_stb1", n, 30);
      tick();
      check_val("rstf_ovr_pre", overrun, 1);
      wait_stb(100, n); check_val("rstf_stb2", n, 31);
      check_val("rstf_valid_pre", m_valid, 1);
      check_val("rstf_pdmclk_pre", pdm_clk_out, 1);
      rst = 1'b1;
      #1;
      check_val("rstf_valid", m_valid, 0);
      check_val("rstf_ovr", overrun, 0);
      check_val("rstf_pdmclk", pdm_clk_out, 0);
      check_val("rstf_stb", dec_stb, 0);
      check_val("rstf_busy", busy, 0);
      tick(); tick();
      m_ready = 1'b1;
      rst = 1'b0;
      stb_cnt = 0;
      wait_valid(200, n);
      check_val("rstf_relat", n, 131);
      check_val("rstf_restb", stb_cnt, 4);
      check_word("rstf_first", 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
